// File: rtl/async_fifo_pkg.sv
// Shared types and pointer-code helpers for the async FIFO read and write sides.
package async_fifo_pkg;

    localparam int ADDRSIZE_DEF = 4;
    localparam int DATASIZE_DEF = 8;

    typedef logic [ADDRSIZE_DEF:0]   ptr_t;
    typedef logic [ADDRSIZE_DEF-1:0] addr_t;
    typedef logic [DATASIZE_DEF-1:0] data_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return (b >> 1) ^ b;
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        for (int i = 0; i <= ADDRSIZE_DEF; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/custom_rptr_empty_fwft_if.sv
// Consumer-side handshake of the FWFT read port.
interface custom_rptr_empty_fwft_if #(
    parameter int DATASIZE = async_fifo_pkg::DATASIZE_DEF
);
    logic                ren;
    logic [DATASIZE-1:0] rdata;
    logic                rvalid;
    logic                fifo_empty;
    logic                fifo_almost_empty;
    logic                rd_underflow;

    modport master (
        output ren,
        input  rdata, rvalid, fifo_empty, fifo_almost_empty, rd_underflow
    );

    modport slave (
        input  ren,
        output rdata, rvalid, fifo_empty, fifo_almost_empty, rd_underflow
    );
endinterface

// File: rtl/custom_gray2bin.sv
// Combinational Gray-to-binary converter; bit i is the XOR of all Gray bits at or above i.
module custom_gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < W; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/custom_rptr_empty_fwft.sv
// Read-domain pointer/empty controller with a first-word-fall-through output register.
module custom_rptr_empty_fwft
    import async_fifo_pkg::*;
#(
    parameter int ADDRSIZE      = ADDRSIZE_DEF,
    parameter int DATASIZE      = DATASIZE_DEF,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                     rclk_i,
    input  logic                     rrst_n_i,
    custom_rptr_empty_fwft_if.slave  rd,
    input  logic [ADDRSIZE:0]        wptr_sync2_rdclk,
    input  logic [DATASIZE-1:0]      rdata_mem,
    output logic [ADDRSIZE-1:0]      rd_addr,
    output logic [ADDRSIZE:0]        rptr_g
);

    localparam logic [ADDRSIZE:0] THRESH = (ADDRSIZE+1)'(AEMPTY_THRESH);

    logic [ADDRSIZE:0]   rbin_reg;
    logic [ADDRSIZE:0]   rbin_next;
    logic [ADDRSIZE:0]   rgray_next;
    logic [ADDRSIZE:0]   wbin_sync;
    logic [ADDRSIZE:0]   level_next;
    logic                mem_empty;
    logic                mem_empty_val;
    logic                pop;
    logic [DATASIZE-1:0] rdata_q;
    logic                rvalid_q;
    logic                aempty_q;
    logic                underflow_q;

    custom_gray2bin #(.W(ADDRSIZE+1)) u_wptr_g2b (
        .gray (wptr_sync2_rdclk),
        .bin  (wbin_sync)
    );

    // Memory is only popped when it has a word and the output register is free or being drained.
    assign pop           = ~mem_empty & (~rvalid_q | rd.ren);
    assign rbin_next     = rbin_reg + {{ADDRSIZE{1'b0}}, pop};
    assign rgray_next    = (rbin_next >> 1) ^ rbin_next;
    assign mem_empty_val = (rgray_next == wptr_sync2_rdclk);
    // Modulo subtraction keeps a full memory (MSBs differ) distinct from an empty one.
    assign level_next    = wbin_sync - rbin_next;
    assign rd_addr       = rbin_reg[ADDRSIZE-1:0];

    always_ff @(posedge rclk_i) begin
        if (!rrst_n_i) begin
            rbin_reg    <= '0;
            rptr_g      <= '0;
            mem_empty   <= 1'b1;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            aempty_q    <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            rbin_reg    <= rbin_next;
            rptr_g      <= rgray_next;
            mem_empty   <= mem_empty_val;
            aempty_q    <= (level_next <= THRESH) | mem_empty_val;
            underflow_q <= rd.ren & ~rvalid_q;
            if (pop) begin
                rdata_q  <= rdata_mem;
                rvalid_q <= 1'b1;
            end else if (rd.ren & rvalid_q) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign rd.rdata             = rdata_q;
    assign rd.rvalid            = rvalid_q;
    assign rd.fifo_empty        = ~rvalid_q;
    assign rd.fifo_almost_empty = aempty_q;
    assign rd.rd_underflow      = underflow_q;

endmodule

// File: tb/tb_custom_rptr_empty_fwft.sv
// Directed bench for the FWFT read-side controller with a word-count reference model.
module tb_custom_rptr_empty_fwft;

    logic       clk = 1'b0;
    logic       rrst_n;
    logic [4:0] wptr;
    logic [7:0] rdata_mem;
    logic [3:0] rd_addr;
    logic [4:0] rptr_g;

    logic [7:0] mem [16];
    logic [7:0] words [64];
    int         wcnt;

    int n_chk = 0;
    int n_err = 0;

    custom_rptr_empty_fwft_if #(.DATASIZE(8)) rd_if ();

    custom_rptr_empty_fwft #(
        .ADDRSIZE(4), .DATASIZE(8), .AEMPTY_THRESH(2)
    ) dut (
        .rclk_i           (clk),
        .rrst_n_i         (rrst_n),
        .rd               (rd_if.slave),
        .wptr_sync2_rdclk (wptr),
        .rdata_mem        (rdata_mem),
        .rd_addr          (rd_addr),
        .rptr_g           (rptr_g)
    );

    assign rdata_mem = mem[rd_addr];

    always #5 clk = ~clk;

    function automatic logic [4:0] gray5(input int b);
        int m;
        m = b % 32;
        return 5'(m ^ (m >> 1));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: counts of words written/read, output word and flags.
    int         m_rcnt;
    int         m_avail;
    logic       m_ov, m_uf, m_ae, m_live = 1'b0;
    logic [7:0] m_od;

    always @(posedge clk) begin
        if (!rrst_n) begin
            m_rcnt  <= 0;
            m_avail <= 0;
            m_ov    <= 1'b0;
            m_od    <= 8'h00;
            m_uf    <= 1'b0;
            m_ae    <= 1'b1;
            m_live  <= 1'b1;
        end else if (m_live) begin
            automatic bit take = (m_avail > 0) && (!m_ov || rd_if.ren);
            automatic int nr   = m_rcnt + (take ? 1 : 0);
            m_uf    <= rd_if.ren && !m_ov;
            if (take) begin
                m_od <= words[m_rcnt];
                m_ov <= 1'b1;
            end else if (rd_if.ren && m_ov) begin
                m_ov <= 1'b0;
            end
            m_rcnt  <= nr;
            m_avail <= wcnt - nr;
            m_ae    <= (wcnt - nr) <= 2;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("rvalid",     32'(rd_if.rvalid),            32'(m_ov));
            chk("rdata",      32'(rd_if.rdata),             32'(m_od));
            chk("fifo_empty", 32'(rd_if.fifo_empty),        32'(!m_ov));
            chk("aempty",     32'(rd_if.fifo_almost_empty), 32'(m_ae));
            chk("underflow",  32'(rd_if.rd_underflow),      32'(m_uf));
            chk("rd_addr",    32'(rd_addr),                 32'(m_rcnt % 16));
            chk("rptr_g",     32'(rptr_g),                  32'(gray5(m_rcnt)));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            words[wcnt+i]      = base + 8'(i);
            mem[(wcnt+i) % 16] = base + 8'(i);
        end
        wcnt = wcnt + n;
        wptr = gray5(wcnt);
    endtask

    task automatic wait_rv(input logic want, input int max, input string nm);
        int n;
        n = 0;
        while (rd_if.rvalid !== want && n < max) begin
            cyc();
            n++;
        end
        chk(nm, 32'(rd_if.rvalid), 32'(want));
    endtask

    task automatic do_reset();
        rrst_n    = 1'b0;
        wcnt      = 0;
        wptr      = 5'd0;
        cyc();
        rrst_n    = 1'b1;
    endtask

    initial begin
        rrst_n    = 1'b0;
        rd_if.ren = 1'b0;
        wcnt      = 0;
        wptr      = 5'd0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        for (int i = 0; i < 64; i++) words[i] = 8'h00;
        cyc();
        cyc();
        chk("rst_rvalid",  32'(rd_if.rvalid),            32'h0);
        chk("rst_empty",   32'(rd_if.fifo_empty),        32'h1);
        chk("rst_aempty",  32'(rd_if.fifo_almost_empty), 32'h1);
        chk("rst_rd_addr", 32'(rd_addr),                 32'h0);
        chk("rst_rptr_g",  32'(rptr_g),                  32'h0);
        rrst_n    = 1'b1;
        rd_if.ren = 1'b1;
        cyc();
        chk("uf_pulse1", 32'(rd_if.rd_underflow), 32'h1);
        cyc();
        chk("uf_pulse2", 32'(rd_if.rd_underflow), 32'h1);
        rd_if.ren = 1'b0;
        cyc();
        chk("uf_clear", 32'(rd_if.rd_underflow), 32'h0);

        // single word: visible two edges after the pointer change
        push(1, 8'hA5);
        cyc();
        chk("a5_n1_rvalid", 32'(rd_if.rvalid), 32'h0);
        cyc();
        chk("a5_rvalid",  32'(rd_if.rvalid),            32'h1);
        chk("a5_rdata",   32'(rd_if.rdata),             32'hA5);
        chk("a5_rd_addr", 32'(rd_addr),                 32'h1);
        chk("a5_rptr_g",  32'(rptr_g),                  32'h01);
        chk("a5_aempty",  32'(rd_if.fifo_almost_empty), 32'h1);

        // back-to-back streaming of 8 words
        rd_if.ren = 1'b1;
        push(8, 8'h10);
        cyc();
        chk("stream_gap", 32'(rd_if.rvalid), 32'h0);
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("stream_rvalid", 32'(rd_if.rvalid), 32'h1);
            chk("stream_rdata",  32'(rd_if.rdata),  32'(8'h10 + 8'(i)));
        end
        cyc();
        chk("stream_end", 32'(rd_if.rvalid), 32'h0);
        rd_if.ren = 1'b0;
        cyc();

        // full memory: level 16 must not look empty
        do_reset();
        cyc();
        push(16, 8'h80);
        cyc();
        chk("full_aempty", 32'(rd_if.fifo_almost_empty), 32'h0);
        chk("full_rvalid", 32'(rd_if.rvalid),            32'h0);
        cyc();
        chk("full_rvalid2", 32'(rd_if.rvalid), 32'h1);
        chk("full_rdata",   32'(rd_if.rdata),  32'h80);
        rd_if.ren = 1'b1;
        wait_rv(1'b0, 40, "full_drain");

        // pointer wrap: stream up to 30 words, then cross 31 -> 32 with a multi-word jump
        while (wcnt < 30) begin
            push(1, 8'h40 + 8'(wcnt));
            cyc();
        end
        wait_rv(1'b0, 20, "wrap_predrain");
        chk("wrap_pre_addr", 32'(rd_addr), 32'd14);
        push(1, 8'h70);
        cyc();
        push(3, 8'h71);
        cyc();
        wait_rv(1'b0, 20, "wrap_drain");
        chk("wrap_rd_addr", 32'(rd_addr), 32'd2);
        chk("wrap_rptr_g",  32'(rptr_g),  32'b00011);

        // reset while streaming
        push(6, 8'hC0);
        wait_rv(1'b1, 10, "mid_stream_up");
        cyc();
        rrst_n = 1'b0;
        wcnt   = 0;
        wptr   = 5'd0;
        cyc();
        chk("mid_rvalid",  32'(rd_if.rvalid),            32'h0);
        chk("mid_rdata",   32'(rd_if.rdata),             32'h0);
        chk("mid_rd_addr", 32'(rd_addr),                 32'h0);
        chk("mid_rptr_g",  32'(rptr_g),                  32'h0);
        chk("mid_aempty",  32'(rd_if.fifo_almost_empty), 32'h1);
        chk("mid_uf",      32'(rd_if.rd_underflow),      32'h0);
        rrst_n    = 1'b1;
        rd_if.ren = 1'b0;
        cyc();
        push(2, 8'hE0);
        wait_rv(1'b1, 10, "restart_up");
        chk("restart_rdata", 32'(rd_if.rdata), 32'hE0);
        rd_if.ren = 1'b1;
        repeat (4) cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
